// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle WIDTH-bit adder/subtractor that walks the
// operands CHUNK bits per clock, LSB chunk first. Operands are held in
// shift registers so the narrow arithmetic core always sees the low
// CHUNK bits, and the partial result is shifted in from the top so that
// after N chunks it sits in its final bit positions.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_carry;
  logic [WIDTH-1:0] chunk_ext;
  logic             bit_a;
  logic             bit_b;
  logic             bit_x;
  logic             chain_c;

  // Ripple the running carry/borrow through the low CHUNK bits of the operands.
  always_comb begin
    chunk_sum = '0;
    chain_c   = carry_q;
    bit_a     = 1'b0;
    bit_b     = 1'b0;
    bit_x     = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      bit_a        = a_q[i];
      bit_b        = b_q[i];
      bit_x        = bit_a ^ bit_b;
      chunk_sum[i] = bit_x ^ chain_c;
      if (mode_q) begin
        chain_c = (~bit_a & bit_b) | (~bit_x & chain_c);
      end else begin
        chain_c = (bit_a & bit_b) | (bit_x & chain_c);
      end
    end
    chunk_carry = chain_c;
    chunk_ext   = WIDTH'(chunk_sum);
  end

  // Next-state and datapath update: accept in IDLE, one chunk per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          part_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        part_d  = (part_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
        carry_d = chunk_carry;
        if (cnt_q == LAST) begin
          result_d = part_d;
          cout_d   = chunk_carry;
          if (mode_q) begin
            ovf_d = (a_msb_q != b_msb_q) && (part_d[WIDTH-1] != a_msb_q);
          end else begin
            ovf_d = (a_msb_q == b_msb_q) && (part_d[WIDTH-1] != a_msb_q);
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor generalising the single-bit full subtractor to WIDTH-bit operands with add/subtract mode select and carry/borrow input. It processes CHUNK bits per clock through a small FSM with start/done handshake, leaving the arithmetic core narrow and reusable across the benchmark datapaths.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥2.
- CHUNK, 1: bits processed per cycle; WIDTH must be an integer multiple of CHUNK; N = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = add (a + b + cin), 1 = subtract (a − b − cin).
- cin  input  1  carry-in (add) or borrow-in (subtract).
- a  input  WIDTH  minuend / addend; latched on accepted start.
- b  input  WIDTH  subtrahend / addend; latched on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking valid results.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry-out (add) or borrow-out (subtract).
- overflow  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN. RUN contains a chunk counter 0..N−1.
- IDLE: if start=1 at a clock edge, latch a, b, mode, cin; clear the internal partial result; load the running carry/borrow with cin; go to RUN with the counter at 0. Otherwise stay.
- RUN: each cycle, combine chunk [counter·CHUNK +: CHUNK] of a and b with the running carry/borrow and write that result chunk. Add uses full-adder semantics. Subtract uses full-subtractor semantics: per bit, d = a^b^bin and bout = (~a&b)|(~(a^b)&bin).
- On the last chunk (counter = N−1):
  - copy the partial result to result;
  - set cout to the final carry/borrow;
  - compute overflow: for add, a[MSB]==b[MSB] and result[MSB]!=a[MSB]; for subtract, a[MSB]!=b[MSB] and result[MSB]!=a[MSB];
  - pulse done and return to IDLE.
- result, cout and overflow change only at completion. They hold their values until the next completion. Partial chunks are never visible on result.
- cout in subtract mode = 1 exactly when a < b + cin, unsigned.
- start while busy is ignored; there is no queueing. Input changes during RUN have no effect.
- Reset mid-operation aborts it: no done pulse, outputs return to reset values.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0; FSM in IDLE; counter 0.
- Start accepted at edge k: busy=1 from edge k through edge k+N−1.
- At edge k+N: done=1 for one cycle, busy=0, and result, cout and overflow are valid. Latency is N cycles, start to done.
- done and busy are never high together.
- start held high on the done cycle is accepted at edge k+N+1. Back-to-back throughput is one operation per N+1 cycles.
- start held continuously restarts on every IDLE cycle.
- N=1 (CHUNK=WIDTH): done asserts one cycle after start.

## Test plan
- WIDTH=8, CHUNK=1, add, a=0x5A, b=0x3C, cin=0 -> after 8 cycles done=1, result=0x96, cout=0, overflow=1. busy high exactly 8 cycles.
- Subtract a=0x05, b=0x07, cin=0 -> result=0xFE, cout=1, overflow=0. Subtract a=0x80, b=0x01 -> result=0x7F, cout=0, overflow=1.
- Add a=0xFF, b=0x00, cin=1 -> result=0x00, cout=1, overflow=0. Subtract a=0x00, b=0x00, cin=1 -> result=0xFF, cout=1, overflow=0.
- WIDTH=4, CHUNK=2: all 16×16×2 operand/cin pairs in both modes, run back-to-back with start held high. Each done arrives 2 cycles after acceptance with an N+1 = 3-cycle period; every result matches a reference model.
- Pulse start again at cycle 3 of a WIDTH=8 add of 0x01+0x01. The second request is ignored, and result=0x02 appears at cycle 8.
- Assert rst at cycle 4 of an operation -> all outputs 0 immediately with no done pulse. A new start after release completes normally.
